uart_receiver: RTL
==================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel UART receiver, 8N1 by default: 1 start, 8 data, 1 stop bit.
//  Receive end of the team's UART link. Recovers bytes from an asynchronous serial line
//  by oversampling at CLKS_PER_BIT clocks per bit and sampling each bit at mid-bit.
//  Presents each byte with a one-cycle valid strobe to the consuming logic.
// PARAMETERS
//  CLKS_PER_BIT  87  clocks per bit period (i_clk / baud); legal range >= 8
//  MSB_FIRST     0   0: first data bit -> o_rx_byte[0]; 1: first data bit -> o_rx_byte[7]
// PORTS
//  i_clk            in   1  system clock, rising edge
//  i_rst_n          in   1  asynchronous active-low reset
//  i_rx_serial      in   1  serial line; asynchronous; idle high
//  o_rx_dv          out  1  one-cycle pulse: o_rx_byte holds a new valid byte
//  o_rx_byte        out  8  last good received byte; held until the next good frame
//  o_rx_active      out  1  high from start-bit detection to end of frame
//  o_rx_frame_err   out  1  one-cycle pulse: stop bit sampled low
//  o_rx_parity_err  out  1  one-cycle pulse: parity mismatch (only with UART_RX_PARITY_EN)
// BEHAVIOUR
//  Reset
//  - Outputs: o_rx_dv=0, o_rx_byte=8'h00, o_rx_active=0, all err=0.
//  - Synchronizer flops reset to 1. FSM resets to IDLE. Counters reset to 0.
//  - Reset mid-frame aborts the frame with no strobes. The next frame is received normally.
//  Input path
//  - i_rx_serial passes through a 2-flop synchronizer, giving rx_s.
//  - All decisions use rx_s only.
//  Timing values
//  - H = (CLKS_PER_BIT-1)/2, integer division.
//  - clk_cnt width is $clog2(CLKS_PER_BIT).
//  - bit_idx is 3 bits.
//  FSM
//  - IDLE: rx_s==0 -> START, clk_cnt=0, o_rx_active=1.
//  - START: count to H. At clk_cnt==H:
//      rx_s==0 -> DATA, clk_cnt=0, bit_idx=0.
//      rx_s==1 -> IDLE, o_rx_active=0. Treated as a glitch; no strobe.
//  - DATA: at clk_cnt==CLKS_PER_BIT-1, sample rx_s into shift reg and set clk_cnt=0.
//      bit_idx<7: bit_idx+1.
//      bit_idx==7: go to PARITY if the macro is defined, else STOP.
//  - PARITY (macro only): at clk_cnt==CLKS_PER_BIT-1, sample the parity bit -> STOP.
//  - STOP: at clk_cnt==CLKS_PER_BIT-1, sample rx_s.
//      rx_s==1 with no parity error: o_rx_byte<=shift reg, o_rx_dv=1 for one cycle -> IDLE.
//      rx_s==1 with parity error: o_rx_parity_err=1 for one cycle, byte not updated -> IDLE.
//      rx_s==0: o_rx_frame_err=1 for one cycle, byte not updated, no o_rx_dv -> WAIT_HIGH.
//  - WAIT_HIGH: stay until rx_s==1 -> IDLE. A break condition never retriggers START.
//  - o_rx_active drops in the same cycle the FSM enters IDLE or WAIT_HIGH.
//  Latency
//  - o_rx_dv rises 3+H+9*CLKS_PER_BIT clocks after the input falling edge.
//  - With the macro, add CLKS_PER_BIT.
//  - Bench tolerance is +/-1 clock for edge-to-clock phase.
//  Other boundary rules
//  - The next frame may start in the cycle after the STOP sample. Back-to-back frames
//    with zero idle time must all be received.
//  - o_rx_dv and the err pulses are mutually exclusive.
//  - No flow control: the consumer must take the byte before the next o_rx_dv.
// CONFIGURATION
//  UART_RX_PARITY_EN
//  - Defined: one even-parity bit follows the data bits (frame 8E1).
//      Parity mismatch -> o_rx_parity_err pulse, no o_rx_dv, o_rx_byte unchanged.
//      A framing error takes priority over a parity error.
//  - Undefined: 8N1 framing, no PARITY state, o_rx_parity_err port absent.
// STRUCTURE
//  - uart_pkg: FSM state encoding localparams, parity type constant, frame length constants.
//    Shared with uart_transmitter.
//  - Sub-module uart_rx_sync: 2-flop synchronizer with async active-low reset, reset value 1.
//  - Remaining logic is FSM, counters and shift register, all inline.
// TESTING (CLKS_PER_BIT=16, MSB_FIRST=0)
//  1. Frame 0xA5, LSB first -> exactly one o_rx_dv, o_rx_byte=8'hA5, no err, active low after.
//  2. Back-to-back 0x00, 0xFF, 0x3C with no idle -> three o_rx_dv, bytes in order.
//  3. Line low for 5 clks then high -> no strobes, o_rx_active pulses then returns to 0.
//  4. Frame 0x5A with stop bit low, then line held low 40 clks, then frame 0x81 ->
//     o_rx_frame_err once, o_rx_byte keeps previous value, then o_rx_dv with 8'h81.
//  5. i_rst_n asserted after data bit 3 of 0xC3 -> all outputs 0 immediately, no strobe;
//     the next frame 0x11 is received correctly.
//  6. (UART_RX_PARITY_EN) 0x07 with parity bit 0, then 0x07 with parity 1 ->
//     o_rx_parity_err once, then o_rx_dv with 8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: UART frame constants, FSM state encoding and parity helper shared by receiver and transmitter
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam logic PARITY_ODD = 1'b0;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the asynchronous serial line, resets to the idle-high level
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);
  logic r_meta;
  logic r_sync;
  // two-stage capture of the asynchronous line
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end
  assign o_sync = r_sync;
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampling UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 framing with a parity-error strobe
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx_serial,
  output logic                 o_rx_dv,
  output logic [DATA_BITS-1:0] o_rx_byte,
  output logic                 o_rx_active,
`ifdef UART_RX_PARITY_EN
  output logic                 o_rx_frame_err,
  output logic                 o_rx_parity_err
`else
  output logic                 o_rx_frame_err
`endif
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam uart_state_e ST_AFTER_DATA = ST_PARITY;
`else
  localparam uart_state_e ST_AFTER_DATA = ST_STOP;
`endif

  logic                 w_rx_s;
  uart_state_e          r_state;
  uart_state_e          w_next;
  logic [CW-1:0]        r_clk_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_rx_dv;
  logic [DATA_BITS-1:0] r_rx_byte;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 w_cnt_last;
  logic                 w_cnt_half;
  logic                 w_sample_data;
  logic                 w_stop_sample;
  logic                 w_par_bad;
  logic                 w_good;
  logic                 w_frame_err;
  logic                 w_parity_err;
  logic                 w_active;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bit;
`endif

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_rx_serial),
    .o_sync  (w_rx_s)
  );

  assign w_cnt_last = (r_clk_cnt == CNT_LAST);
  assign w_cnt_half = (r_clk_cnt == CNT_HALF);

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // FSM next-state decode; START re-checks the line at mid-bit to reject glitches
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (!w_rx_s) w_next = ST_START;
      ST_START:     if (w_cnt_half) w_next = w_rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:      if (w_cnt_last && r_bit_idx == IDX_LAST) w_next = ST_AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      ST_PARITY:    if (w_cnt_last) w_next = ST_STOP;
`endif
      ST_STOP:      if (w_cnt_last) w_next = w_rx_s ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (w_rx_s) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // FSM output decode; a low stop bit wins over a parity mismatch
  always_comb begin
    w_sample_data = (r_state == ST_DATA) && w_cnt_last;
    w_stop_sample = (r_state == ST_STOP) && w_cnt_last;
`ifdef UART_RX_PARITY_EN
    w_par_bad     = (r_par_bit != parity_bit(r_shift));
`else
    w_par_bad     = 1'b0;
`endif
    w_frame_err   = w_stop_sample && !w_rx_s;
    w_good        = w_stop_sample && w_rx_s && !w_par_bad;
    w_parity_err  = w_stop_sample && w_rx_s && w_par_bad;
    w_active      = (r_state != ST_IDLE) && (r_state != ST_WAIT_HIGH);
  end

  // bit-period counter restarts on every state change and at each bit boundary
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                                       r_clk_cnt <= '0;
    else if (w_next != r_state || r_state == ST_IDLE || w_cnt_last)     r_clk_cnt <= '0;
    else                                                                r_clk_cnt <= r_clk_cnt + 1'b1;
  end

  // data bit index and shift register, loaded at each mid-bit sample
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_bit_idx <= (r_state != ST_DATA) ? 3'd0 : (w_sample_data ? r_bit_idx + 3'd1 : r_bit_idx);
      if (w_sample_data)
        r_shift <= MSB_FIRST ? {r_shift[DATA_BITS-2:0], w_rx_s} : {w_rx_s, r_shift[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // capture of the received parity bit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                  r_par_bit <= 1'b0;
    else if (r_state == ST_PARITY && w_cnt_last)   r_par_bit <= w_rx_s;
  end
`endif

  // registered strobes; the byte register only changes on a good frame
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_dv      <= 1'b0;
      r_rx_byte    <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_rx_dv      <= w_good;
      r_frame_err  <= w_frame_err;
      r_parity_err <= w_parity_err;
      if (w_good) r_rx_byte <= r_shift;
    end
  end

  assign o_rx_dv        = r_rx_dv;
  assign o_rx_byte      = r_rx_byte;
  assign o_rx_active    = w_active;
  assign o_rx_frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
  assign o_rx_parity_err = r_parity_err;
`else
  logic w_unused;
  assign w_unused = r_parity_err;
`endif
endmodule
